dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 75 +++++++
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory responder and its lane aligner.
//   - default storage depth and response latency
//   - RV32I load/store funct3 encodings
//   - responder state encoding
package dmem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_LATENCY     = 2;

  // RV32I load/store size/sign encodings (stores only use B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 32-bit word.
// Ports:
//   we          in   1 = store, 0 = load
//   funct3      in   RV32I access size/sign
//   addr_lo     in   byte offset within the word
//   wdata       in   right-aligned store data
//   rword       in   current contents of the addressed word
//   byte_en     out  lanes to write (all 0 for loads and errors)
//   wdata_lane  out  store data replicated onto every lane
//   rdata_ext   out  extracted and extended load data (0 for stores and errors)
//   err         out  illegal funct3 or misaligned access
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default first, so no path through the case leaves a latch.
  always_comb begin
    shifted    = rword >> {addr_lo, 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = shifted[15:0];
    byte_en    = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    err        = 1'b0;

    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        err        = addr_lo[0];
        byte_en    = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        err        = |addr_lo;
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      // Unsigned variants exist only for loads
      F3_BU: begin
        err       = we;
        rdata_ext = {24'b0, byte_sel};
      end
      F3_HU: begin
        err       = we | addr_lo[0];
        rdata_ext = {16'b0, half_sel};
      end
      default: err = 1'b1;
    endcase

    if (err || !we) byte_en   = '0;
    if (err || we)  rdata_ext = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with fixed latency.
// A request is accepted in IDLE, waits LATENCY cycles, then the store is
// committed / load data captured on the edge entering RESP. The response is
// held until rsp_ready.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_we, req_addr,
//   req_funct3, req_wdata     request payload (byte address, RV32I funct3)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        load data (0 for stores/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              commit;
  logic              cur_we;
  logic [AW-1:0]     cur_addr;
  logic [2:0]        cur_funct3;
  logic [31:0]       cur_wdata;
  logic [IDX_W-1:0]  cur_idx;
  logic [31:0]       cur_word;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lane;
  logic [31:0]       rdata_ext;
  logic              lane_err;
  logic              unused_addr_hi;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid & req_ready;

  // Address bits above the storage size alias onto the same words
  assign unused_addr_hi = ^req_addr[31:AW];

  // With LATENCY=1 the commit happens on the accept edge itself, so the
  // aligner must see the live request rather than the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we     = req_we;
      cur_addr   = req_addr[AW-1:0];
      cur_funct3 = req_funct3;
      cur_wdata  = req_wdata;
    end else begin
      cur_we     = we_q;
      cur_addr   = addr_q;
      cur_funct3 = funct3_q;
      cur_wdata  = wdata_q;
    end
  end

  assign cur_idx  = cur_addr[AW-1:2];
  assign cur_word = mem_q[cur_idx];

  dmem_lane_align u_align (
    .we         (cur_we),
    .funct3     (cur_funct3),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rword      (cur_word),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (lane_err)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    commit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          addr_d   = req_addr[AW-1:0];
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            rdata_d = rdata_ext;
            err_d   = lane_err;
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          rdata_d = rdata_ext;
          err_d   = lane_err;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state updates use non-blocking assignments so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; contents
  // survive reset. The write is still gated by rst so a store cannot land
  // while reset is held.
  always_ff @(posedge clk) begin
    if (commit && rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// A byte-array reference model computes expected load data and error flags
// from access size, alignment and sign rules; directed vectors and random
// traffic are compared against it and against literal expected values.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Reference model: byte-addressed memory, size/sign from funct3.
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size;
    int base;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    rd = '0;
    er = (size == 0) || (we && f3[2]);
    if (!er) er = (addr % size) != 0;
    if (!er) begin
      base = int'(addr % (DEPTH * 4));
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[base+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd = rd | (32'(ref_mem[base+i]) << (8*i));
        if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8*size));
      end
    end
  endtask

  // Drive one request, measure latency, hold the response `hold` cycles,
  // then complete the handshake. DUT results are checked against the model.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int n;
    int lat;
    model(we, addr, f3, wd, exp_rd, exp_er);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL accept_timeout addr=%h", addr); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL latency addr=%h got=%0d exp=%0d", addr, lat, LAT); end
    rd = rsp_rdata;
    er = rsp_err;
    checks++;
    if (rd !== exp_rd || er !== exp_er) begin
      errors++;
      $display("FAIL model_cmp we=%b f3=%b addr=%h got=%h/%b exp=%h/%b", we, f3, addr, rd, er, exp_rd, exp_er);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold valid=%b rdata=%h ready=%b exp 1/%h/0", rsp_valid, rsp_rdata, req_ready, rd);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL resp_release valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b rdata=%h err=%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_prefill();
    logic [31:0] rd;
    logic er;
    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w*4), F3_W, $urandom, 0, rd, er);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs [15] = '{
    '{1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0},
    '{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0},
    '{1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0},
    '{1'b0, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0},
    '{1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFFDEAD, 1'b0},
    '{1'b0, 32'h10, 3'b101, 32'h0,        32'h0000BEEF, 1'b0},
    '{1'b1, 32'h11, 3'b000, 32'h55,       32'h0,        1'b0},
    '{1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0},
    '{1'b1, 32'h12, 3'b001, 32'h1234,     32'h0,        1'b0},
    '{1'b0, 32'h10, 3'b010, 32'h0,        32'h123455EF, 1'b0},
    '{1'b0, 32'h12, 3'b010, 32'h0,        32'h0,        1'b1},
    '{1'b1, 32'h11, 3'b001, 32'hFFFF,     32'h0,        1'b1},
    '{1'b0, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1},
    '{1'b1, 32'h10, 3'b100, 32'hFF,       32'h0,        1'b1},
    '{1'b0, 32'h10, 3'b010, 32'h0,        32'h123455EF, 1'b0}
  };

  task automatic test_directed();
    logic [31:0] rd;
    logic er;
    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, 0, rd, er);
      checks++;
      if (rd !== vecs[i].rd || er !== vecs[i].er) begin
        errors++;
        $display("FAIL directed_%0d got=%h/%b exp=%h/%b", i, rd, er, vecs[i].rd, vecs[i].er);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic er;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_W; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== LAT || rsp_rdata !== 32'h123455EF) begin
      errors++;
      $display("FAIL bp_first lat=%0d rdata=%h exp %0d/123455ef", lat, rsp_rdata, LAT);
    end
    // Stray store presented while busy must be ignored
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_funct3 = F3_W; req_wdata = 32'h0BAD0BAD;
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h123455EF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d valid=%b rdata=%h ready=%b exp 1/123455ef/0", k, rsp_valid, rsp_rdata, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
    issue(1'b0, 32'h10, F3_W, '0, 0, rd, er);
    checks++;
    if (rd !== 32'h123455EF) begin errors++; $display("FAIL bp_no_queue got=%h exp=123455ef", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    issue(1'b1, 32'h20, F3_W, 32'h11112222, 0, rd, er);
    issue(1'b0, 32'h20, F3_W, '0, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = F3_W; req_wdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_async valid=%b rdata=%h err=%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 32'h20, F3_W, '0, 0, rd, er);
    checks++;
    if (rd !== 32'h11112222) begin errors++; $display("FAIL rst_dropped_store got=%h exp=11112222", rd); end
    issue(1'b0, 32'h420, F3_W, '0, 1, rd, er);
    checks++;
    if (rd !== 32'h11112222) begin errors++; $display("FAIL alias_read got=%h exp=11112222", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] addr;
    logic er;
    for (int i = 0; i < 80; i++) begin
      addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
           | (32'($urandom_range(0, 7)) << 10);
      issue(1'($urandom_range(0, 1)), addr, 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3), rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
